ps2_key_fifo: RTL and testbench

PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

---
 rtl/ps2_key_fifo_pkg.sv | 23 ++
 rtl/ps2_key_fifo_if.sv | 38 +++
 rtl/ps2_rx.sv | 115 +++++++++++
 rtl/ps2_key_fifo.sv | 110 +++++++++++
 tb/tb_ps2_key_fifo.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_fifo_pkg.sv
// rtl/ps2_key_fifo_pkg.sv - shared receiver state encoding and xkey field positions
package ps2_key_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam int XKEY_READY_POS = 31;
    localparam int XKEY_OVF_POS   = 30;
    localparam int XKEY_ERR_POS   = 29;
    localparam int XKEY_COUNT_LSB = 16;
    localparam int XKEY_LAST_LSB  = 8;
    localparam int XKEY_DATA_LSB  = 0;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_fifo_if.sv
// rtl/ps2_key_fifo_if.sv - register-side pop/clear strobes and key status bus
interface ps2_key_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          clr_err;
    logic [7:0]    key_data;
    logic          key_ready;
    logic [CW-1:0] count;
    logic          overflow;
    logic          err;
    logic [31:0]   xkey;

    modport master (
        output rd_en,
        output clr_err,
        input  key_data,
        input  key_ready,
        input  count,
        input  overflow,
        input  err,
        input  xkey
    );

    modport slave (
        input  rd_en,
        input  clr_err,
        output key_data,
        output key_ready,
        output count,
        output overflow,
        output err,
        output xkey
    );

endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 synchronizer, clock glitch filter and 11-bit frame receiver
module ps2_rx
    import ps2_key_fifo_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_filt;
    logic [FW-1:0] f_cnt;
    logic          fall;

    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic [TW-1:0] t_cnt;

    logic d_bit;
    logic timeout;

    assign d_bit   = d_sync[1];
    assign timeout = (state != IDLE) && !fall && (t_cnt == TMO_LAST);

    // fall pulses for one cycle right after the filtered clock goes 1 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
            c_filt <= 1'b1;
            f_cnt  <= '0;
            fall   <= 1'b0;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            fall   <= 1'b0;
            if (c_sync[1] == c_filt) begin
                f_cnt <= '0;
            end else if (f_cnt == FILT_LAST) begin
                c_filt <= c_sync[1];
                f_cnt  <= '0;
                fall   <= c_filt;
            end else begin
                f_cnt <= f_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_ok     <= 1'b0;
            t_cnt      <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            t_cnt      <= (state == IDLE || fall) ? '0 : t_cnt + 1'b1;
            if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!d_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {d_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= odd_parity_ok(shift, d_bit);
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (d_bit && par_ok) begin
                            data_byte  <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 keyboard receiver feeding a show-ahead scan-code FIFO
module ps2_key_fifo
    import ps2_key_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PS2C,
    input  logic         PS2D,
    ps2_key_fifo_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    last_byte;
    logic          overflow_q;
    logic          err_q;

    logic empty;
    logic full;
    logic pop;
    logic do_push;
    logic drop;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2c      (PS2C),
        .ps2d      (PS2D),
        .data_byte (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_push = rx_valid && (!full || pop);
    assign drop    = rx_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            last_byte  <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(pop);
            if (rx_valid) begin
                last_byte <= rx_byte;
            end
            overflow_q <= drop   || (overflow_q && !bus.clr_err);
            err_q      <= rx_err || (err_q && !bus.clr_err);
        end
    end

    assign bus.key_ready = !empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.err       = err_q;

    always_comb begin
        bus.key_data = 8'h00;
        if (!empty) begin
            bus.key_data = mem[rd_ptr];
        end
    end

    always_comb begin
        bus.xkey                              = 32'h0;
        bus.xkey[XKEY_READY_POS]              = !empty;
        bus.xkey[XKEY_OVF_POS]                = overflow_q;
        bus.xkey[XKEY_ERR_POS]                = err_q;
        bus.xkey[XKEY_COUNT_LSB +: 8]         = 8'(count_q);
        bus.xkey[XKEY_LAST_LSB +: 8]          = last_byte;
        bus.xkey[XKEY_DATA_LSB +: 8]          = bus.key_data;
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - self-checking bench for ps2_key_fifo
module tb_ps2_key_fifo;
    import ps2_key_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
    localparam int TMO   = 400;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic PS2C = 1'b1;
    logic PS2D = 1'b1;

    ps2_key_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_key_fifo #(
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (FLEN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .PS2C(PS2C),
        .PS2D(PS2D),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_err;
    logic [7:0] m_last;

    typedef struct {
        logic [7:0] d;
        bit         bad_par;
        bit         bad_stop;
        bit         pop_after;
        bit         clr_after;
        int         exp_cnt;
        bit         exp_err;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_err  = 1'b0;
        m_last = 8'h00;
    endtask

    task automatic m_frame(input logic [7:0] d, input bit good);
        if (good) begin
            m_last = d;
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0]  head;
        logic [31:0] xk;
        head = (mq.size() > 0) ? mq[0] : 8'h00;
        xk   = {(mq.size() > 0) ? 1'b1 : 1'b0, m_ovf, m_err, 5'b0, 8'(mq.size()), m_last, head};
        chk({tag, ".count"},     32'(bus.count),     32'(mq.size()));
        chk({tag, ".key_ready"}, 32'(bus.key_ready), 32'(mq.size() > 0));
        chk({tag, ".key_data"},  32'(bus.key_data),  32'(head));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        chk({tag, ".err"},       32'(bus.err),       32'(m_err));
        chk({tag, ".xkey"},      bus.xkey,           xk);
    endtask

    task automatic ps2_bit(input logic b);
        PS2D = b;
        wait_cycles(HALF);
        PS2C = 1'b0;
        wait_cycles(HALF);
        PS2C = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = d;
        fr[9]   = ~(^d) ^ bad_par;
        fr[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        PS2D = 1'b1;
        wait_cycles(6);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        send_bits(d, bad_par, bad_stop, 11);
        m_frame(d, !(bad_par || bad_stop));
    endtask

    task automatic do_pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        wait_cycles(1);
    endtask

    task automatic do_clr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        m_ovf = 1'b0;
        m_err = 1'b0;
        wait_cycles(1);
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            chk({tag, ".pop_data"}, 32'(bus.key_data), 32'(mq[0]));
            do_pop();
        end
        check_all({tag, ".drained"});
    endtask

    initial begin
        logic [7:0] popped;
        bit         seen;
        int         kind;
        logic [7:0] rd;

        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        m_reset();

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 8'h1C};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 8'h00};
        vecs[2] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h29};
        vecs[3] = '{8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'h29};
        vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 8'h29};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 8'hF0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 8'h00};

        wait_cycles(3);
        chk("reset.xkey_in_reset", bus.xkey, 32'h0);
        rst = 1'b0;
        wait_cycles(2);
        check_all("reset");

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].bad_stop);
            chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d.err", i), 32'(bus.err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.key_data", i), 32'(bus.key_data), 32'(vecs[i].exp_head));
            chk($sformatf("vec%0d.key_ready", i), 32'(bus.key_ready), 32'(vecs[i].exp_cnt != 0));
            if (vecs[i].pop_after) do_pop();
            if (vecs[i].clr_after) do_clr();
            check_all($sformatf("vec%0d.after", i));
        end
        drain("table");

        // short PS2C glitches with data low must not start a frame
        PS2D = 1'b0;
        for (int i = 0; i < 10; i++) begin
            PS2C = 1'b0;
            wait_cycles(2);
            PS2C = 1'b1;
            wait_cycles(5);
        end
        PS2D = 1'b1;
        wait_cycles(20);
        check_all("glitch");
        chk("glitch.state", 32'(dut.u_rx.state), 32'(IDLE));
        send_frame(8'h42, 1'b0, 1'b0);
        check_all("glitch.next_frame");
        drain("glitch");

        // frame abandoned after 4 data bits
        send_bits(8'hA5, 1'b0, 1'b0, 5);
        wait_cycles(TMO + 100);
        m_err = 1'b1;
        check_all("timeout");
        chk("timeout.state", 32'(dut.u_rx.state), 32'(IDLE));
        do_clr();
        send_frame(8'h29, 1'b0, 1'b0);
        check_all("timeout.next_frame");
        drain("timeout");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        chk("ovf.count", 32'(bus.count), 32'(DEPTH));
        chk("ovf.flag", 32'(bus.overflow), 32'h1);
        check_all("ovf");
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf.pop%0d", i), 32'(bus.key_data), 32'(i));
            do_pop();
        end
        check_all("ovf.empty");
        do_clr();
        check_all("ovf.cleared");

        // full FIFO with a pop landing on the push cycle of 0x77
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
        check_all("coinc.full");
        send_bits(8'h77, 1'b0, 1'b0, 10);
        PS2D = 1'b1;
        wait_cycles(HALF);
        PS2C = 1'b0;
        seen   = 1'b0;
        popped = 8'h00;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (dut.u_rx.byte_valid) begin
                seen       = 1'b1;
                popped     = bus.key_data;
                bus.rd_en  = 1'b1;
                @(negedge clk);
                bus.rd_en  = 1'b0;
            end
        end
        chk("coinc.push_seen", 32'(seen), 32'h1);
        chk("coinc.popped", 32'(popped), 32'h10);
        wait_cycles(HALF);
        PS2C = 1'b1;
        wait_cycles(6);
        void'(mq.pop_front());
        m_frame(8'h77, 1'b1);
        chk("coinc.overflow", 32'(bus.overflow), 32'h0);
        chk("coinc.count", 32'(bus.count), 32'(DEPTH));
        check_all("coinc");
        for (int i = 0; i < 8; i++) begin
            rd = (i == 7) ? 8'h77 : 8'h11 + 8'(i);
            chk($sformatf("coinc.pop%0d", i), 32'(bus.key_data), 32'(rd));
            do_pop();
        end
        check_all("coinc.empty");

        // reset in the middle of a frame
        send_frame(8'h55, 1'b0, 1'b0);
        send_bits(8'h3C, 1'b0, 1'b0, 5);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        m_reset();
        wait_cycles(2);
        check_all("midrst");
        send_frame(8'h3C, 1'b0, 1'b0);
        check_all("midrst.next_frame");

        for (int n = 0; n < 25; n++) begin
            rd   = 8'($urandom);
            kind = $urandom_range(0, 5);
            send_frame(rd, kind == 0, kind == 1);
            check_all($sformatf("rnd%0d.frame", n));
            for (int p = $urandom_range(0, 2); p > 0; p--) do_pop();
            if ($urandom_range(0, 3) == 0) do_clr();
            check_all($sformatf("rnd%0d.after", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
